// File: rtl/pwr_pkg.sv
// Shared power-mode definitions: decoder-facing mode codes, sequencer state enum, fault codes.
// Imported by power_state_ctrl, the enable/clock-speed decoder and their benches.
package pwr_pkg;

    localparam logic [2:0] MODE_RESET     = 3'b000;
    localparam logic [2:0] MODE_NORMAL    = 3'b001;
    localparam logic [2:0] MODE_LOW_POWER = 3'b010;
    localparam logic [2:0] MODE_FAULT     = 3'b100;

    localparam int RST_HOLD_DEF   = 16;
    localparam int PG_TIMEOUT_DEF = 1024;
    localparam int LP_DWELL_DEF   = 256;
    localparam int CNT_W_DEF      = 12;

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_PWRUP      = 3'd1,
        ST_NORMAL     = 3'd2,
        ST_LOW_POWER  = 3'd3,
        ST_FAULT      = 3'd4
    } pwr_state_e;

    typedef enum logic [1:0] {
        FC_NONE       = 2'b00,
        FC_PG_TIMEOUT = 2'b01,
        FC_PG_LOST    = 2'b10,
        FC_EXT        = 2'b11
    } fault_code_e;

    // PWRUP reports NORMAL so the decoder ramps clocks while power-good is being verified.
    function automatic logic [2:0] mode_of(input pwr_state_e s);
        case (s)
            ST_RESET_HOLD: return MODE_RESET;
            ST_PWRUP:      return MODE_NORMAL;
            ST_NORMAL:     return MODE_NORMAL;
            ST_LOW_POWER:  return MODE_LOW_POWER;
            default:       return MODE_FAULT;
        endcase
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/power_state_ctrl.sv
// Power-mode sequencer: reset hold, power-up with power-good check, normal, dwell-qualified
// low power, wake-up and latched fault. All outputs are registered from the next state.
module power_state_ctrl
    import pwr_pkg::*;
#(
    parameter int RST_HOLD   = RST_HOLD_DEF,
    parameter int PG_TIMEOUT = PG_TIMEOUT_DEF,
    parameter int LP_DWELL   = LP_DWELL_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lp_req,
    input  logic       wake,
    input  logic       pg,
    input  logic       fault_in,
    input  logic       fault_clr,
    output logic [2:0] current_state,
    output logic       state_valid,
    output logic [1:0] fault_code,
    output logic       busy
);

    pwr_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [1:0]       fc_nxt;
    logic             pg_sync;

    sync_2ff u_pg_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pg),
        .q     (pg_sync)
    );

    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fc_nxt    = fault_code;
        if (fault_in) begin
            state_nxt = ST_FAULT;
            fc_nxt    = FC_EXT;
        end else begin
            case (state)
                ST_RESET_HOLD: begin
                    if (cnt == CNT_W'(RST_HOLD - 1)) state_nxt = ST_PWRUP;
                    else                             cnt_nxt   = cnt_inc;
                end
                ST_PWRUP: begin
                    if (pg_sync) begin
                        state_nxt = ST_NORMAL;
                    end else if (cnt == CNT_W'(PG_TIMEOUT - 1)) begin
                        state_nxt = ST_FAULT;
                        fc_nxt    = FC_PG_TIMEOUT;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                ST_NORMAL: begin
                    // Power loss outranks a dwell that completes on the same cycle.
                    if (!pg_sync) begin
                        state_nxt = ST_FAULT;
                        fc_nxt    = FC_PG_LOST;
                    end else if (lp_req) begin
                        if (cnt == CNT_W'(LP_DWELL - 1)) state_nxt = ST_LOW_POWER;
                        else                             cnt_nxt   = cnt_inc;
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                ST_LOW_POWER: begin
                    // Rail is boosted back up through PWRUP so pg gets re-verified.
                    if (wake || !lp_req) state_nxt = ST_PWRUP;
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state_nxt = ST_RESET_HOLD;
                        fc_nxt    = FC_NONE;
                    end
                end
                default: begin
                    state_nxt = ST_FAULT;
                    fc_nxt    = FC_EXT;
                end
            endcase
        end
        if (state_nxt != state) cnt_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RESET_HOLD;
            cnt           <= '0;
            current_state <= MODE_RESET;
            state_valid   <= 1'b0;
            fault_code    <= FC_NONE;
            busy          <= 1'b1;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            current_state <= mode_of(state_nxt);
            state_valid   <= (state_nxt == ST_NORMAL) || (state_nxt == ST_LOW_POWER);
            fault_code    <= fc_nxt;
            busy          <= (state_nxt == ST_RESET_HOLD) || (state_nxt == ST_PWRUP);
        end
    end

endmodule
